npp_interface_out: RTL and testbench
====================================

// Module: npp_interface_out
// PURPOSE
//  Egress counterpart of the NPP ingress adapter: takes flits from the NoC side
//  (valid packed as MSB of noc_data, plus head/tail) and presents them to the NPP
//  port as npp_valid/npp_data/npp_head/npp_tail with npp_ready backpressure.
//  Buffers flits in a small FIFO, checks head/tail framing, drops malformed flits.
// PARAMETERS
//  DATA_WIDTH  128  flit payload width
//  DEPTH       4    FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1               single clock domain, all logic rising-edge
//  rst         in   1               asynchronous, active-high reset
//  noc_data    in   DATA_WIDTH+1    {valid, payload}; bit DATA_WIDTH = flit valid
//  head        in   1               first flit of packet (qualified by noc_data MSB)
//  tail        in   1               last flit of packet (head&tail = 1-flit packet)
//  noc_ready   out  1               FIFO can accept a flit this cycle
//  npp_ready   in   1               NPP sink accepts the presented flit
//  npp_valid   out  1               flit presented on npp_*
//  npp_data    out  DATA_WIDTH      flit payload
//  npp_head    out  1               head marker of presented flit
//  npp_tail    out  1               tail marker of presented flit
//  proto_err   out  1               sticky framing-error flag
//  fifo_level  out  $clog2(DEPTH+1) entries currently held in FIFO
// BEHAVIOUR
//  Reset (async, rst=1): npp_valid=0, npp_data=0, npp_head=0, npp_tail=0,
//   proto_err=0, fifo_level=0, noc_ready=1, framing FSM=IDLE, pointers=0.
//  Input handshake: flit accepted when noc_data[DATA_WIDTH] & noc_ready.
//   noc_ready = (fifo_level != DEPTH); combinational from count only, no
//   pass-through of npp_ready. Valid with noc_ready=0: flit not taken; sender holds.
//  Framing FSM (on accepted flits only), states IDLE, IN_PKT:
//   IDLE  : head=1,tail=1 -> push, stay IDLE; head=1,tail=0 -> push, IN_PKT;
//           head=0 -> drop, proto_err<=1, stay IDLE.
//   IN_PKT: head=0,tail=0 -> push; head=0,tail=1 -> push, IDLE;
//           head=1 -> drop, proto_err<=1, stay IN_PKT.
//   Dropped flits still count as accepted (noc_ready unaffected); not written.
//  FIFO stores {head,tail,payload}; pointers wrap modulo DEPTH.
//  Output stage: registered. Loaded from FIFO head when npp_valid=0 or
//   (npp_valid & npp_ready); npp_valid<=0 if FIFO empty at that point.
//   npp_* hold stable while npp_valid & !npp_ready.
//  Latency: flit accepted in cycle N on empty FIFO/idle output -> npp_valid in N+1.
//  Throughput: 1 flit/cycle sustained when npp_ready=1 and FIFO not full.
//  Simultaneous push and pop: level unchanged; allowed at any level < DEPTH;
//   at full, no push (noc_ready=0) while pop proceeds.
//  fifo_level excludes the flit in the output register.
//  proto_err cleared only by rst. Reset mid-packet discards FIFO and output flit.
// STRUCTURE
//  npp_pkg: localparams FLIT_W = DATA_WIDTH+2, HEAD_BIT/TAIL_BIT field indices,
//   framing state encodings (IDLE=1'b0, IN_PKT=1'b1).
//  Sub-module npp_flit_fifo: sync FIFO (width FLIT_W, DEPTH), push/pop/full/
//   empty/level, async active-high reset; top holds FSM and output register.
// TESTING
//  1-flit packet 0xA5 (head=tail=1), npp_ready=1 -> npp_valid one cycle later,
//   npp_data=0xA5, npp_head=npp_tail=1; proto_err stays 0.
//  4-flit packet 0..3, npp_ready=0 throughout -> 1 flit in output reg, level=3;
//   send 2 more flits -> level=4, noc_ready=0; raise npp_ready -> 0,1,2,3 in order.
//  Body flit (head=0) while IDLE -> dropped, npp_valid stays 0, proto_err=1 sticky.
//  Head flit mid-packet (IN_PKT) -> dropped, packet completes with original tail.
//  Back-to-back 8 flits, npp_ready toggling 1,0,1,0 -> no loss/dup, order kept,
//   npp_* stable during npp_ready=0 cycles.
//  rst pulse mid-packet with level=2 -> all outputs to reset values immediately,
//   next head flit accepted normally.

Source files
------------

// File: rtl/npp_pkg.sv
// rtl/npp_pkg.sv - shared constants and types for the NPP egress adapter
package npp_pkg;

  localparam int NPP_DATA_W = 128;
  localparam int FLIT_W     = NPP_DATA_W + 2;
  localparam int TAIL_BIT   = NPP_DATA_W;
  localparam int HEAD_BIT   = NPP_DATA_W + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_e;

  // A flit is well framed when it opens a packet from IDLE or continues one in IN_PKT
  function automatic logic framing_ok(input frame_state_e st, input logic head);
    return (st == IDLE) ? head : !head;
  endfunction

endpackage

// File: rtl/npp_flit_fifo.sv
// rtl/npp_flit_fifo.sv - synchronous flit FIFO with occupancy count
module npp_flit_fifo #(
  parameter int WIDTH = 130,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/npp_interface_out.sv
// rtl/npp_interface_out.sv - NoC-to-NPP egress adapter with framing check
module npp_interface_out
  import npp_pkg::*;
#(
  parameter int DATA_WIDTH = NPP_DATA_W,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH:0]        noc_data,
  input  logic                       head,
  input  logic                       tail,
  output logic                       noc_ready,
  input  logic                       npp_ready,
  output logic                       npp_valid,
  output logic [DATA_WIDTH-1:0]      npp_data,
  output logic                       npp_head,
  output logic                       npp_tail,
  output logic                       proto_err,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int FW = DATA_WIDTH + 2;

  frame_state_e  state;
  frame_state_e  state_next;
  logic          accept;
  logic          frame_ok;
  logic          err_set;
  logic          out_load;
  logic          bypass;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_rdata;
  logic [FW-1:0] in_flit;

  assign accept    = noc_data[DATA_WIDTH] & noc_ready;
  assign in_flit   = {head, tail, noc_data[DATA_WIDTH-1:0]};
  assign noc_ready = ~fifo_full;

  // Output register reloads whenever it is empty or its flit is being consumed.
  // With nothing queued, a good incoming flit goes straight to the output so an
  // idle adapter presents it on the very next cycle.
  assign out_load  = ~npp_valid | npp_ready;
  assign bypass    = out_load & fifo_empty & frame_ok;
  assign fifo_push = frame_ok & ~bypass;
  assign fifo_pop  = out_load & ~fifo_empty;

  npp_flit_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (in_flit),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Framing state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Framing decision for the accepted flit: keep it or drop it and flag an error
  always_comb begin
    state_next = state;
    frame_ok   = 1'b0;
    err_set    = 1'b0;
    if (accept) begin
      if (framing_ok(state, head)) begin
        frame_ok   = 1'b1;
        state_next = tail ? IDLE : IN_PKT;
      end else begin
        err_set = 1'b1;
      end
    end
  end

  // Sticky framing error, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          proto_err <= 1'b0;
    else if (err_set) proto_err <= 1'b1;
  end

  // Output register: FIFO head has priority over the bypass path to keep order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      npp_valid <= 1'b0;
      npp_data  <= '0;
      npp_head  <= 1'b0;
      npp_tail  <= 1'b0;
    end else if (out_load) begin
      if (!fifo_empty) begin
        npp_valid <= 1'b1;
        npp_head  <= fifo_rdata[FW-1];
        npp_tail  <= fifo_rdata[FW-2];
        npp_data  <= fifo_rdata[DATA_WIDTH-1:0];
      end else if (bypass) begin
        npp_valid <= 1'b1;
        npp_head  <= head;
        npp_tail  <= tail;
        npp_data  <= noc_data[DATA_WIDTH-1:0];
      end else begin
        npp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_npp_interface_out.sv
// tb/tb_npp_interface_out.sv - self-checking bench for npp_interface_out
module tb_npp_interface_out;

  localparam int DW    = 128;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW:0]   noc_data;
  logic          head;
  logic          tail;
  logic          noc_ready;
  logic          npp_ready;
  logic          npp_valid;
  logic [DW-1:0] npp_data;
  logic          npp_head;
  logic          npp_tail;
  logic          proto_err;
  logic [2:0]    fifo_level;

  int checks   = 0;
  int failures = 0;

  // Reference: every flit that survived framing and is not yet consumed, oldest first
  logic [DW+1:0] q[$];
  bit            m_in_pkt;
  bit            m_err;

  npp_interface_out #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .noc_data   (noc_data),
    .head       (head),
    .tail       (tail),
    .noc_ready  (noc_ready),
    .npp_ready  (npp_ready),
    .npp_valid  (npp_valid),
    .npp_data   (npp_data),
    .npp_head   (npp_head),
    .npp_tail   (npp_tail),
    .proto_err  (proto_err),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW+1:0] got, input logic [DW+1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Flits held = output register (if any) + FIFO, so the FIFO holds all but one
  function automatic int m_level();
    return (q.size() > 0) ? q.size() - 1 : 0;
  endfunction

  task automatic check_outputs();
    check("npp_valid", npp_valid, q.size() > 0);
    check("fifo_level", fifo_level, m_level());
    check("noc_ready", noc_ready, m_level() != DEPTH);
    check("proto_err", proto_err, m_err);
    if (q.size() > 0) check("npp_flit", {npp_head, npp_tail, npp_data}, q[0]);
  endtask

  // One clock: check at negedge, drive, advance the model across the posedge
  task automatic cycle(input bit v, input bit h, input bit t, input logic [DW-1:0] d,
                       input bit r, output bit acc);
    bit take;
    check_outputs();
    noc_data  = {v, d};
    head      = h;
    tail      = t;
    npp_ready = r;
    acc  = v && (m_level() != DEPTH);
    take = r && (q.size() > 0);
    @(posedge clk);
    if (take) void'(q.pop_front());
    if (acc) begin
      if (m_in_pkt ? !h : h) begin
        q.push_back({h, t, d});
        m_in_pkt = !t;
      end else begin
        m_err = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit r);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, r, acc);
  endtask

  // Sender that holds a flit until taken; an exhausted budget is a failure
  task automatic send(input bit h, input bit t, input logic [DW-1:0] d, input bit r);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      cycle(1'b1, h, t, d, r, acc);
      n++;
    end
    if (!acc) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    noc_data  = '0;
    head      = 1'b0;
    tail      = 1'b0;
    npp_ready = 1'b0;
    #1;
    check("rst_valid", npp_valid, 1'b0);
    check("rst_data", npp_data, '0);
    check("rst_head_tail", {npp_head, npp_tail}, 2'b00);
    check("rst_err", proto_err, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_noc_ready", noc_ready, 1'b1);
    q.delete();
    m_in_pkt = 1'b0;
    m_err    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit acc;
    bit pend;
    bit ph, pt, s_in;
    logic [DW-1:0] pd;

    rst = 1'b0;
    #2;
    do_reset();

    // Single-flit packet straight through
    cycle(1'b1, 1'b1, 1'b1, 'hA5, 1'b1, acc);
    idle(3, 1'b1);

    // 4-flit packet with sink stalled, then overfill, then drain in order
    for (int i = 0; i < 4; i++) cycle(1'b1, i == 0, i == 3, DW'(i), 1'b0, acc);
    cycle(1'b1, 1'b1, 1'b1, 'd4, 1'b0, acc);
    cycle(1'b1, 1'b1, 1'b1, 'd5, 1'b0, acc);
    idle(8, 1'b1);

    // Body flit while idle is dropped; error is sticky
    cycle(1'b1, 1'b0, 1'b0, 'h77, 1'b1, acc);
    idle(3, 1'b1);

    // Head flit inside a packet is dropped; packet closes with its own tail
    send(1'b1, 1'b0, 'd10, 1'b1);
    send(1'b1, 1'b0, 'd11, 1'b1);
    send(1'b0, 1'b1, 'd12, 1'b1);
    idle(3, 1'b1);

    // Back-to-back 8-flit packet with sink toggling
    for (int i = 0; i < 8; i++) send(i == 0, i == 7, DW'(20 + i), i % 2 == 0);
    for (int i = 0; i < 8; i++) idle(1, i % 2 == 0);

    // Reset mid-packet with two flits queued, then resume normally
    send(1'b1, 1'b0, 'd40, 1'b0);
    send(1'b0, 1'b0, 'd41, 1'b0);
    send(1'b0, 1'b0, 'd42, 1'b0);
    check_outputs();
    do_reset();
    send(1'b1, 1'b1, 'd50, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic with mostly legal framing and random backpressure
    pend = 1'b0;
    s_in = 1'b0;
    ph   = 1'b0;
    pt   = 1'b0;
    pd   = '0;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      if (i == 400) s_in = 1'b0;
      if (i == 400) pend = 1'b0;
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        pd   = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 19) == 0) begin
          ph = 1'($urandom);
          pt = 1'($urandom);
        end else begin
          ph = !s_in;
          pt = ($urandom_range(0, 2) == 0);
        end
      end
      cycle(pend, ph, pt, pd, $urandom_range(0, 2) != 0, acc);
      if (acc) begin
        pend = 1'b0;
        if (ph == !s_in) s_in = !pt;
      end
    end
    idle(8, 1'b1);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
